sp_issue_scoreboard: RTL and testbench
======================================

// Module: sp_issue_scoreboard
// PURPOSE
//  Issue stage feeding the single-precision execution pipe, and receiver of its two writeback streams.
//  - Owns a 128 x 128-bit register file.
//  - Reads source operands, stalls decoded instructions on RAW hazards via a per-register pending-write scoreboard.
//  - Drives registered operands/opcode into the pipe; commits rt_wb (stage 6) and rt_int (stage 7) results.
// PARAMETERS
//  NREG     128  architectural registers (address width 7)
//  CNT_W    3    width of per-register outstanding-write counter
//  STAT_W   32   width of issue/stall statistics counters
// PORTS
//  clk            in   1    clock; all state updates on rising edge
//  reset          in   1    synchronous, active-high reset
//  in_valid       in   1    decoded instruction present
//  in_ready       out  1    instruction accepted this edge when in_valid&in_ready
//  in_op          in   11   decoded opcode (format-truncated)
//  in_format      in   3    instruction format
//  in_rt_addr     in   7    destination register
//  in_ra_addr/in_rb_addr/in_rc_addr  in 7 each  source registers
//  in_src_mask    in   3    [2]=ra,[1]=rb,[0]=rc used (hazard check only)
//  in_imm         in   18   immediate
//  in_reg_write   in   1    instruction writes rt
//  op/format/rt_addr/imm/reg_write  out 11/3/7/18/1  registered to pipe
//  ra, rb, rc     out  128 each  registered operand values to pipe
//  rt_wb, rt_addr_wb, reg_write_wb     in 128/7/1  pipe stage-6 writeback
//  rt_int, rt_addr_int, reg_write_int  in 128/7/1  pipe stage-7 (integer) writeback
//  dbg_addr       in   7    debug read address
//  dbg_data       out  128  combinational regfile[dbg_addr] (post-write view not required)
//  issue_cnt      out  32   instructions issued since reset
//  stall_cnt      out  32   cycles with in_valid=1 and in_ready=0
// BEHAVIOUR
//  Reset: regfile, all pending counters, all pipe outputs, issue_cnt, stall_cnt <= 0; in_ready=0 while reset=1.
//  Writeback: each edge, reg_write_wb writes rt_wb to rt_addr_wb; reg_write_int writes rt_int to rt_addr_int.
//   Same address both ports same edge -> rt_wb wins (younger instr).
//  Scoreboard: pend[r] (CNT_W bits).
//   - +1 on accept with in_reg_write=1 for r=in_rt_addr.
//   - -1 per writeback port with reg_write=1 targeting r (up to -2/edge).
//   - Inc and decs same edge net out; never underflows (decrement at 0 ignored, regfile still written).
//  Effective pending eff[r] = pend[r] minus writebacks to r this cycle.
//  Hazard = any masked source s with eff[s]!=0, or (in_reg_write and pend[in_rt_addr]==2^CNT_W-1).
//   - in_ready = !reset && !hazard (combinational).
//  Operand read: value = rt_wb if reg_write_wb && addr match; else rt_int if reg_write_int && match; else regfile.
//   - Bypass applies to all three sources regardless of mask.
//  Accept edge: pipe outputs <= in_* fields and bypassed ra/rb/rc; issue_cnt+1.
//   - Pipe samples them the following edge; issue latency 1 cycle.
//  Non-accept edge: pipe outputs <= nop (op=0, format=0, rt_addr=0, imm=0, reg_write=0, ra=rb=rc=0).
//  stall_cnt +1 each edge with in_valid=1, in_ready=0, reset=0. Counters wrap at 2^32.
//  WAW is not stalled: pipe latencies preserve write order (wb-over-int priority covers same-edge case).
//  Reset mid-operation: all pending cleared; writebacks arriving later still write regfile, no underflow.
// TESTING
//  1 Hold reset 3 cycles -> in_ready=0, all outputs 0; release -> in_ready=1, dbg_data(r17)=0, counters 0.
//  2 Drive rt_wb=128'h1..., addr 3, reg_write_wb=1; next cycle issue fa rt=5 ra=3 rb=4 -> ra out=128'h1..., rb=0,
//    reg_write=1, issue_cnt=1.
//  3 Issue fa rt=5; then fa ra=5 valid -> in_ready=0 until rt_wb addr 5 driven; that cycle in_ready=1,
//    ra=bypassed rt_wb value, stall_cnt = stalled cycles.
//  4 Same edge rt_wb=A addr 9 and rt_int=B addr 9 -> dbg_data(9)=A.
//  5 Issue mpy rt=7 twice (pend[7]=2); one rt_int addr 7 -> a reader of r7 stays stalled;
//    second rt_int -> in_ready=1.
//  6 Issue with pend[2]=1, assert reset 1 cycle -> pend cleared, reader of r2 accepted immediately after reset.

Source files
------------

// File: rtl/sp_issue_scoreboard.sv
// sp_issue_scoreboard
// Issue stage for the single-precision execution pipe. Holds the 128 x 128-bit
// register file, tracks outstanding writes per register so RAW hazards stall
// at issue, and commits the two pipe writeback streams (stage 6 and stage 7).
module sp_issue_scoreboard #(
    parameter int NREG   = 128,
    parameter int CNT_W  = 3,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [10:0]       in_op,
    input  logic [2:0]        in_format,
    input  logic [6:0]        in_rt_addr,
    input  logic [6:0]        in_ra_addr,
    input  logic [6:0]        in_rb_addr,
    input  logic [6:0]        in_rc_addr,
    input  logic [2:0]        in_src_mask,
    input  logic [17:0]       in_imm,
    input  logic              in_reg_write,
    output logic [10:0]       op,
    output logic [2:0]        format,
    output logic [6:0]        rt_addr,
    output logic [17:0]       imm,
    output logic              reg_write,
    output logic [127:0]      ra,
    output logic [127:0]      rb,
    output logic [127:0]      rc,
    input  logic [127:0]      rt_wb,
    input  logic [6:0]        rt_addr_wb,
    input  logic              reg_write_wb,
    input  logic [127:0]      rt_int,
    input  logic [6:0]        rt_addr_int,
    input  logic              reg_write_int,
    input  logic [6:0]        dbg_addr,
    output logic [127:0]      dbg_data,
    output logic [STAT_W-1:0] issue_cnt,
    output logic [STAT_W-1:0] stall_cnt
);

    logic [127:0]     r_regfile [NREG];
    logic [CNT_W-1:0] r_pend    [NREG];

    logic w_raWbHit, w_raIntHit;
    logic w_rbWbHit, w_rbIntHit;
    logic w_rcWbHit, w_rcIntHit;
    logic w_rtFull;
    logic w_hazard;
    logic w_accept;
    logic [127:0] w_raVal, w_rbVal, w_rcVal;

    // A source is still busy if its pending count exceeds the writebacks landing this cycle.
    function automatic logic stillBusy(input logic [CNT_W-1:0] p, input logic d1, input logic d2);
        logic [CNT_W:0] dec;
        dec = {{CNT_W{1'b0}}, d1} + {{CNT_W{1'b0}}, d2};
        return ({1'b0, p} > dec);
    endfunction

    // Pending count after an optional issue increment and up to two writeback decrements, floored at zero.
    function automatic logic [CNT_W-1:0] nextPend(input logic [CNT_W-1:0] p, input logic inc,
                                                  input logic d1, input logic d2);
        logic [CNT_W:0] sum;
        logic [CNT_W:0] dec;
        sum = {1'b0, p} + {{CNT_W{1'b0}}, inc};
        dec = {{CNT_W{1'b0}}, d1} + {{CNT_W{1'b0}}, d2};
        return (sum > dec) ? CNT_W'(sum - dec) : '0;
    endfunction

    assign w_raWbHit  = reg_write_wb  && (rt_addr_wb  == in_ra_addr);
    assign w_raIntHit = reg_write_int && (rt_addr_int == in_ra_addr);
    assign w_rbWbHit  = reg_write_wb  && (rt_addr_wb  == in_rb_addr);
    assign w_rbIntHit = reg_write_int && (rt_addr_int == in_rb_addr);
    assign w_rcWbHit  = reg_write_wb  && (rt_addr_wb  == in_rc_addr);
    assign w_rcIntHit = reg_write_int && (rt_addr_int == in_rc_addr);

    // The stage-6 result is younger than the stage-7 one, so it takes priority on the bypass.
    assign w_raVal = w_raWbHit ? rt_wb : (w_raIntHit ? rt_int : r_regfile[in_ra_addr]);
    assign w_rbVal = w_rbWbHit ? rt_wb : (w_rbIntHit ? rt_int : r_regfile[in_rb_addr]);
    assign w_rcVal = w_rcWbHit ? rt_wb : (w_rcIntHit ? rt_int : r_regfile[in_rc_addr]);

    // A saturated destination counter blocks issue even if a writeback lands the same cycle.
    assign w_rtFull = in_reg_write && (r_pend[in_rt_addr] == {CNT_W{1'b1}});

    assign w_hazard = (in_src_mask[2] && stillBusy(r_pend[in_ra_addr], w_raWbHit, w_raIntHit))
                   || (in_src_mask[1] && stillBusy(r_pend[in_rb_addr], w_rbWbHit, w_rbIntHit))
                   || (in_src_mask[0] && stillBusy(r_pend[in_rc_addr], w_rcWbHit, w_rcIntHit))
                   || w_rtFull;

    assign in_ready = !reset && !w_hazard;
    assign w_accept = in_valid && in_ready;
    assign dbg_data = r_regfile[dbg_addr];

    // Register file commit: stage-7 write first so a same-address stage-6 write overrides it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regfile[i] <= '0;
        end else begin
            if (reg_write_int) r_regfile[rt_addr_int] <= rt_int;
            if (reg_write_wb)  r_regfile[rt_addr_wb]  <= rt_wb;
        end
    end

    // Per-register outstanding-write counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_pend[i] <= nextPend(r_pend[i],
                                      w_accept && in_reg_write && (in_rt_addr == 7'(i)),
                                      reg_write_wb  && (rt_addr_wb  == 7'(i)),
                                      reg_write_int && (rt_addr_int == 7'(i)));
            end
        end
    end

    // Pipe-facing registers: the accepted instruction, or a nop bubble otherwise.
    always_ff @(posedge clk) begin
        if (reset || !w_accept) begin
            op        <= '0;
            format    <= '0;
            rt_addr   <= '0;
            imm       <= '0;
            reg_write <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            rc        <= '0;
        end else begin
            op        <= in_op;
            format    <= in_format;
            rt_addr   <= in_rt_addr;
            imm       <= in_imm;
            reg_write <= in_reg_write;
            ra        <= w_raVal;
            rb        <= w_rbVal;
            rc        <= w_rcVal;
        end
    end

    // Issue and stall statistics, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_accept)              issue_cnt <= issue_cnt + 1'b1;
            if (in_valid && !in_ready) stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sp_issue_scoreboard.sv
// tb_sp_issue_scoreboard
// Scenario tasks drive instructions and writebacks on the falling edge and push
// the expected pipe output; a monitor pops and compares after each rising edge.
module tb_sp_issue_scoreboard;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [10:0]   in_op;
    logic [2:0]    in_format;
    logic [6:0]    in_rt_addr, in_ra_addr, in_rb_addr, in_rc_addr;
    logic [2:0]    in_src_mask;
    logic [17:0]   in_imm;
    logic          in_reg_write;
    logic [10:0]   op;
    logic [2:0]    format;
    logic [6:0]    rt_addr;
    logic [17:0]   imm;
    logic          reg_write;
    logic [127:0]  ra, rb, rc;
    logic [127:0]  rt_wb, rt_int;
    logic [6:0]    rt_addr_wb, rt_addr_int;
    logic          reg_write_wb, reg_write_int;
    logic [6:0]    dbg_addr;
    logic [127:0]  dbg_data;
    logic [31:0]   issue_cnt, stall_cnt;

    typedef struct {
        logic [10:0]  op;
        logic [2:0]   fmt;
        logic [6:0]   rt;
        logic [17:0]  imm;
        logic         rw;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [127:0] rc;
    } exp_t;

    exp_t         expQ[$];
    logic [127:0] model [128];
    int           nCompared;
    int           nMismatched;
    int           expIssue;

    localparam logic [10:0] OP_FA  = 11'h0C4;
    localparam logic [10:0] OP_MPY = 11'h3C6;

    sp_issue_scoreboard dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_format(in_format), .in_rt_addr(in_rt_addr),
        .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
        .in_src_mask(in_src_mask), .in_imm(in_imm), .in_reg_write(in_reg_write),
        .op(op), .format(format), .rt_addr(rt_addr), .imm(imm), .reg_write(reg_write),
        .ra(ra), .rb(rb), .rc(rc),
        .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb), .reg_write_wb(reg_write_wb),
        .rt_int(rt_int), .rt_addr_int(rt_addr_int), .reg_write_int(reg_write_int),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: on each edge, an accepted instruction must appear on the pipe outputs, otherwise a nop.
    logic monAcc, monRst;
    exp_t monE;
    always @(posedge clk) begin
        monAcc = in_valid && in_ready;
        monRst = reset;
        #1;
        if (monRst) expIssue = 0;
        else if (monAcc) expIssue = expIssue + 1;
        if (monAcc && !monRst) begin
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL pipe_unexpected_issue: got op=%h, required no accept", op);
            end else begin
                monE = expQ.pop_front();
                if ({op, format, rt_addr, imm, reg_write} !== {monE.op, monE.fmt, monE.rt, monE.imm, monE.rw}) begin
                    nMismatched++;
                    $display("[TB] FAIL pipe_ctrl: got %h/%h/%h/%h/%b required %h/%h/%h/%h/%b",
                             op, format, rt_addr, imm, reg_write, monE.op, monE.fmt, monE.rt, monE.imm, monE.rw);
                end
                nCompared++;
                if (ra !== monE.ra) begin
                    nMismatched++;
                    $display("[TB] FAIL pipe_ra: got %h required %h", ra, monE.ra);
                end
                nCompared++;
                if (rb !== monE.rb) begin
                    nMismatched++;
                    $display("[TB] FAIL pipe_rb: got %h required %h", rb, monE.rb);
                end
                nCompared++;
                if (rc !== monE.rc) begin
                    nMismatched++;
                    $display("[TB] FAIL pipe_rc: got %h required %h", rc, monE.rc);
                end
            end
        end else begin
            nCompared++;
            if ({op, format, rt_addr, imm, reg_write, ra, rb, rc} !== '0) begin
                nMismatched++;
                $display("[TB] FAIL pipe_nop: got op=%h rt=%h rw=%b ra=%h required all zero", op, rt_addr, reg_write, ra);
            end
        end
        nCompared++;
        if (issue_cnt !== 32'(expIssue)) begin
            nMismatched++;
            $display("[TB] FAIL issue_cnt: got %0d required %0d", issue_cnt, expIssue);
        end
    end

    // Drive one decoded instruction and record what the pipe must see when it is accepted.
    task automatic driveIssue(input logic [10:0] o, input logic [6:0] rt, input logic [6:0] a,
                              input logic [6:0] b, input logic [6:0] c, input logic [2:0] mask,
                              input logic rw, input logic [127:0] eRa, input logic [127:0] eRb,
                              input logic [127:0] eRc);
        exp_t e;
        in_valid     = 1'b1;
        in_op        = o;
        in_format    = 3'(o[2:0]);
        in_rt_addr   = rt;
        in_ra_addr   = a;
        in_rb_addr   = b;
        in_rc_addr   = c;
        in_src_mask  = mask;
        in_imm       = 18'($urandom);
        in_reg_write = rw;
        e.op  = o;
        e.fmt = in_format;
        e.rt  = rt;
        e.imm = in_imm;
        e.rw  = rw;
        e.ra  = eRa;
        e.rb  = eRb;
        e.rc  = eRc;
        expQ.push_back(e);
    endtask

    task automatic driveIdle();
        in_valid     = 1'b0;
        in_src_mask  = 3'b000;
        in_reg_write = 1'b0;
    endtask

    task automatic wbOff();
        reg_write_wb  = 1'b0;
        reg_write_int = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        driveIssue(OP_FA, 7'd1, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, '0, '0, '0);
        void'(expQ.pop_back());
        repeat (3) @(negedge clk);
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_ready: got %b required 0", in_ready);
        end
        reset = 1'b0;
        driveIdle();
        dbg_addr = 7'd17;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL release_ready: got %b required 1", in_ready);
        end
        nCompared++;
        if (dbg_data !== 128'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_dbg17: got %h required 0", dbg_data);
        end
        nCompared++;
        if ({issue_cnt, stall_cnt} !== 64'h0) begin
            nMismatched++;
            $display("[TB] FAIL reset_counters: got issue=%0d stall=%0d required 0/0", issue_cnt, stall_cnt);
        end
    endtask

    task automatic test_operand_read();
        logic [127:0] b;
        @(negedge clk);
        rt_wb = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        rt_addr_wb = 7'd3;
        reg_write_wb = 1'b1;
        @(negedge clk);
        wbOff();
        model[3] = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        driveIssue(OP_FA, 7'd5, 7'd3, 7'd4, 7'd0, 3'b110, 1'b1, model[3], model[4], model[0]);
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL operand_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        driveIdle();
        nCompared++;
        if (issue_cnt !== 32'd1) begin
            nMismatched++;
            $display("[TB] FAIL operand_issue_cnt: got %0d required 1", issue_cnt);
        end
        b = rnd128();
        rt_int = b;
        rt_addr_int = 7'd5;
        reg_write_int = 1'b1;
        @(negedge clk);
        wbOff();
        model[5] = b;
    endtask

    task automatic test_raw_stall();
        logic [31:0]  s0;
        logic [127:0] c;
        c = rnd128();
        @(negedge clk);
        driveIssue(OP_FA, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, model[0], model[0], model[0]);
        @(negedge clk);
        s0 = stall_cnt;
        driveIssue(OP_FA, 7'd6, 7'd5, 7'd1, 7'd2, 3'b100, 1'b0, c, model[1], model[2]);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            nCompared++;
            if (in_ready !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL raw_stalled_%0d: got %b required 0", k, in_ready);
            end
        end
        @(negedge clk);
        rt_wb = c;
        rt_addr_wb = 7'd5;
        reg_write_wb = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL raw_release: got %b required 1", in_ready);
        end
        @(negedge clk);
        wbOff();
        driveIdle();
        model[5] = c;
        nCompared++;
        if (stall_cnt !== s0 + 32'd3) begin
            nMismatched++;
            $display("[TB] FAIL raw_stall_cnt: got %0d required %0d", stall_cnt, s0 + 32'd3);
        end
    endtask

    task automatic test_wb_priority();
        logic [127:0] a, b;
        a = rnd128();
        b = ~a;
        @(negedge clk);
        rt_wb = a;
        rt_addr_wb = 7'd9;
        reg_write_wb = 1'b1;
        rt_int = b;
        rt_addr_int = 7'd9;
        reg_write_int = 1'b1;
        @(negedge clk);
        wbOff();
        model[9] = a;
        dbg_addr = 7'd9;
        driveIssue(OP_FA, 7'd11, 7'd9, 7'd0, 7'd0, 3'b100, 1'b0, a, model[0], model[0]);
        #1;
        nCompared++;
        if (dbg_data !== a) begin
            nMismatched++;
            $display("[TB] FAIL wb_priority: got %h required %h", dbg_data, a);
        end
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL wb_no_underflow_ready: got %b required 1", in_ready);
        end
        @(negedge clk);
        driveIdle();
    endtask

    task automatic test_multi_pending();
        logic [127:0] d, e;
        d = rnd128();
        e = rnd128();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            driveIssue(OP_MPY, 7'd7, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, '0, '0, '0);
        end
        @(negedge clk);
        driveIssue(OP_FA, 7'd10, 7'd7, 7'd0, 7'd0, 3'b100, 1'b0, e, '0, '0);
        rt_int = d;
        rt_addr_int = 7'd7;
        reg_write_int = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL multi_first_wb: got %b required 0", in_ready);
        end
        @(negedge clk);
        reg_write_int = 1'b0;
        model[7] = d;
        #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL multi_one_left: got %b required 0", in_ready);
        end
        @(negedge clk);
        rt_int = e;
        reg_write_int = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL multi_second_wb: got %b required 1", in_ready);
        end
        @(negedge clk);
        wbOff();
        driveIdle();
        model[7] = e;
    endtask

    task automatic test_back_to_back_full();
        logic [127:0] f;
        f = rnd128();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            driveIssue(11'(k + 1), 7'd8, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, '0, '0, '0);
            #1;
            nCompared++;
            if (in_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL b2b_ready_%0d: got %b required 1", k, in_ready);
            end
        end
        @(negedge clk);
        driveIssue(OP_FA, 7'd8, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, '0, '0, '0);
        #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_stall: got %b required 0", in_ready);
        end
        @(negedge clk);
        rt_wb = f;
        rt_addr_wb = 7'd8;
        reg_write_wb = 1'b1;
        #1;
        nCompared++;
        if (in_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL full_same_cycle_wb: got %b required 0", in_ready);
        end
        @(negedge clk);
        wbOff();
        model[8] = f;
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL full_release: got %b required 1", in_ready);
        end
        @(negedge clk);
        driveIdle();
    endtask

    task automatic test_reset_mid();
        logic [127:0] g;
        g = rnd128();
        @(negedge clk);
        driveIssue(OP_FA, 7'd2, 7'd0, 7'd0, 7'd0, 3'b000, 1'b1, model[0], model[0], model[0]);
        @(negedge clk);
        driveIdle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 128; r++) model[r] = '0;
        driveIssue(OP_FA, 7'd12, 7'd2, 7'd0, 7'd0, 3'b100, 1'b0, '0, '0, '0);
        #1;
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_ready: got %b required 1", in_ready);
        end
        nCompared++;
        if (stall_cnt !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_mid_stall_cnt: got %0d required 0", stall_cnt);
        end
        @(negedge clk);
        driveIdle();
        rt_int = g;
        rt_addr_int = 7'd2;
        reg_write_int = 1'b1;
        @(negedge clk);
        wbOff();
        model[2] = g;
        dbg_addr = 7'd2;
        driveIssue(OP_FA, 7'd13, 7'd2, 7'd0, 7'd0, 3'b100, 1'b0, g, '0, '0);
        #1;
        nCompared++;
        if (dbg_data !== g) begin
            nMismatched++;
            $display("[TB] FAIL late_wb_data: got %h required %h", dbg_data, g);
        end
        nCompared++;
        if (in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL late_wb_no_underflow: got %b required 1", in_ready);
        end
        @(negedge clk);
        driveIdle();
    endtask

    // Test sequence.
    initial begin
        nCompared   = 0;
        nMismatched = 0;
        expIssue    = 0;
        for (int r = 0; r < 128; r++) model[r] = '0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = '0;
        in_format = '0;
        in_rt_addr = '0;
        in_ra_addr = '0;
        in_rb_addr = '0;
        in_rc_addr = '0;
        in_src_mask = '0;
        in_imm = '0;
        in_reg_write = 1'b0;
        rt_wb = '0;
        rt_addr_wb = '0;
        reg_write_wb = 1'b0;
        rt_int = '0;
        rt_addr_int = '0;
        reg_write_int = 1'b0;
        dbg_addr = '0;

        test_reset();
        test_operand_read();
        test_raw_stall();
        test_wb_priority();
        test_multi_pending();
        test_back_to_back_full();
        test_reset_mid();

        repeat (2) @(negedge clk);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
